// File: rtl/sr_count_driver_if.sv
// Signal bundle between a step requester / SR flip-flop bank and the
// sr_count_driver. The driver sits on the slave modport: it takes step
// requests and flip-flop feedback, and produces the S/R excitation and
// status. The master modport is the requester plus flip-flop bank side.
interface sr_count_driver_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] count;
    logic             ready;
    logic             done;
    logic             wrap;
    logic             err;
    logic [WIDTH-1:0] fault_bits;

    modport master (
        output en, up, load, load_val, q_fb,
        input  s, r, count, ready, done, wrap, err, fault_bits
    );

    modport slave (
        input  en, up, load, load_val, q_fb,
        output s, r, count, ready, done, wrap, err, fault_bits
    );
endinterface

// File: rtl/sr_count_driver.sv
// sr_count_driver: steps an external bank of SR flip-flops through a
// modulo-MODULO up/down count. Each step computes the S/R excitation,
// drives it for one cycle, then checks the flip-flop feedback against the
// target. A feedback mismatch latches a sticky fault until reset.
// s and r are never both high on the same bit.
module sr_count_driver #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    sr_count_driver_if.slave     io_bus
);
    localparam logic [2:0] LP_CLEAR  = 3'd0;
    localparam logic [2:0] LP_IDLE   = 3'd1;
    localparam logic [2:0] LP_DRIVE  = 3'd2;
    localparam logic [2:0] LP_VERIFY = 3'd3;
    localparam logic [2:0] LP_FAULT  = 3'd4;

    localparam logic [WIDTH-1:0] LP_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] LP_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MODULO - 1);

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_r;
    logic             r_ready;
    logic             r_done;
    logic             r_wrap;
    logic             r_err;
    logic [WIDTH-1:0] r_fault_bits;
    logic             r_step_wrap;
    // Set while verifying the post-reset clear, which is not a user step
    // and therefore reports no done/wrap.
    logic             r_from_clear;

    logic [WIDTH-1:0] w_clamp;
    logic [WIDTH-1:0] w_next;
    logic             w_next_wrap;
    logic [WIDTH-1:0] w_req_target;
    logic             w_req_wrap;

    // Request target: clamped load value has priority, otherwise the modulo neighbour of count.
    always_comb begin
        w_clamp      = io_bus.load_val;
        w_next       = r_count;
        w_next_wrap  = 1'b0;
        w_req_target = r_count;
        w_req_wrap   = 1'b0;

        if (io_bus.load_val > LP_MAX) begin
            w_clamp = LP_MAX;
        end else begin
            w_clamp = io_bus.load_val;
        end

        if (io_bus.up) begin
            if (r_count == LP_MAX) begin
                w_next      = LP_ZERO;
                w_next_wrap = 1'b1;
            end else begin
                w_next      = r_count + LP_ONE;
                w_next_wrap = 1'b0;
            end
        end else begin
            if (r_count == LP_ZERO) begin
                w_next      = LP_MAX;
                w_next_wrap = 1'b1;
            end else begin
                w_next      = r_count - LP_ONE;
                w_next_wrap = 1'b0;
            end
        end

        if (io_bus.load) begin
            w_req_target = w_clamp;
            w_req_wrap   = 1'b0;
        end else begin
            w_req_target = w_next;
            w_req_wrap   = w_next_wrap;
        end
    end

    // Sequencer: CLEAR -> VERIFY -> IDLE, then IDLE -> DRIVE -> VERIFY per step; FAULT is terminal.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= LP_CLEAR;
            r_target     <= LP_ZERO;
            r_count      <= LP_ZERO;
            r_s          <= LP_ZERO;
            r_r          <= LP_ONES;
            r_ready      <= 1'b0;
            r_done       <= 1'b0;
            r_wrap       <= 1'b0;
            r_err        <= 1'b0;
            r_fault_bits <= LP_ZERO;
            r_step_wrap  <= 1'b0;
            r_from_clear <= 1'b1;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                LP_CLEAR: begin
                    r_s          <= LP_ZERO;
                    r_r          <= LP_ZERO;
                    r_target     <= LP_ZERO;
                    r_step_wrap  <= 1'b0;
                    r_from_clear <= 1'b1;
                    r_ready      <= 1'b0;
                    r_state      <= LP_VERIFY;
                end
                LP_IDLE: begin
                    if (io_bus.load || io_bus.en) begin
                        r_target     <= w_req_target;
                        r_step_wrap  <= w_req_wrap;
                        r_s          <= ~r_count & w_req_target;
                        r_r          <= r_count & ~w_req_target;
                        r_from_clear <= 1'b0;
                        r_ready      <= 1'b0;
                        r_state      <= LP_DRIVE;
                    end else begin
                        r_s     <= LP_ZERO;
                        r_r     <= LP_ZERO;
                        r_ready <= 1'b1;
                        r_state <= LP_IDLE;
                    end
                end
                LP_DRIVE: begin
                    r_s     <= LP_ZERO;
                    r_r     <= LP_ZERO;
                    r_ready <= 1'b0;
                    r_state <= LP_VERIFY;
                end
                LP_VERIFY: begin
                    r_s <= LP_ZERO;
                    r_r <= LP_ZERO;
                    if (io_bus.q_fb == r_target) begin
                        r_count <= r_target;
                        r_done  <= ~r_from_clear;
                        r_wrap  <= r_step_wrap & ~r_from_clear;
                        r_ready <= 1'b1;
                        r_state <= LP_IDLE;
                    end else begin
                        r_fault_bits <= io_bus.q_fb ^ r_target;
                        r_err        <= 1'b1;
                        r_ready      <= 1'b0;
                        r_state      <= LP_FAULT;
                    end
                end
                LP_FAULT: begin
                    r_s     <= LP_ZERO;
                    r_r     <= LP_ZERO;
                    r_ready <= 1'b0;
                    r_state <= LP_FAULT;
                end
                default: begin
                    // Corrupted state register: park safely with flip-flops untouched.
                    r_s     <= LP_ZERO;
                    r_r     <= LP_ZERO;
                    r_ready <= 1'b0;
                    r_err   <= 1'b1;
                    r_state <= LP_FAULT;
                end
            endcase
        end
    end

    assign io_bus.s          = r_s;
    assign io_bus.r          = r_r;
    assign io_bus.count      = r_count;
    assign io_bus.ready      = r_ready;
    assign io_bus.done       = r_done;
    assign io_bus.wrap       = r_wrap;
    assign io_bus.err        = r_err;
    assign io_bus.fault_bits = r_fault_bits;
endmodule

// File: tb/tb_sr_count_driver.sv
// Directed bench for sr_count_driver with a bank of behavioural SR
// flip-flops closing the feedback loop. Bit-level stuck-at-0 control lets
// a flip-flop be broken to exercise the fault path.
module tb_sr_count_driver;
    localparam int WIDTH  = 4;
    localparam int MODULO = 10;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] ff_q;
    logic [WIDTH-1:0] stuck0;
    logic [3:0]       m_count;
    int               n_cmp;
    int               n_fail;

    sr_count_driver_if #(.WIDTH(WIDTH)) bus ();

    sr_count_driver #(.WIDTH(WIDTH), .MODULO(MODULO)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SR flip-flop bank model; stuck0 forces a bit low.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (stuck0[i]) begin
                ff_q[i] <= 1'b0;
            end else if (bus.s[i]) begin
                ff_q[i] <= 1'b1;
            end else if (bus.r[i]) begin
                ff_q[i] <= 1'b0;
            end else begin
                ff_q[i] <= ff_q[i];
            end
        end
    end

    assign bus.q_fb = ff_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request from IDLE: checks DRIVE excitation, VERIFY quiet, then completion.
    task automatic do_step(input logic ld, input logic [3:0] lv, input logic dir,
                           input logic [3:0] exp_tgt, input logic exp_wrap, input logic hold);
        logic [3:0] exp_s;
        logic [3:0] exp_r;
        exp_s = ~m_count & exp_tgt;
        exp_r = m_count & ~exp_tgt;
        bus.load     = ld;
        bus.load_val = lv;
        bus.en       = 1'b1;
        bus.up       = dir;
        @(negedge clk);
        check("drive_s", 32'(bus.s), 32'(exp_s));
        check("drive_r", 32'(bus.r), 32'(exp_r));
        check("drive_s_and_r", 32'(bus.s & bus.r), 32'd0);
        check("drive_ready", 32'(bus.ready), 32'd0);
        check("drive_done", 32'(bus.done), 32'd0);
        if (!hold) begin
            bus.en   = 1'b0;
            bus.load = 1'b0;
        end
        @(negedge clk);
        check("verify_s", 32'(bus.s), 32'd0);
        check("verify_r", 32'(bus.r), 32'd0);
        check("verify_ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        check("done_count", 32'(bus.count), 32'(exp_tgt));
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_wrap", 32'(bus.wrap), 32'(exp_wrap));
        check("done_ready", 32'(bus.ready), 32'd1);
        check("done_err", 32'(bus.err), 32'd0);
        m_count = exp_tgt;
    endtask

    // Reset pulse of one cycle, then the CLEAR and VERIFY cycles.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst_r", 32'(bus.r), 32'hF);
        check("rst_s", 32'(bus.s), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("clr_verify_r", 32'(bus.r), 32'd0);
        check("clr_verify_q", 32'(bus.q_fb), 32'd0);
        check("clr_verify_ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        check("post_rst_ready", 32'(bus.ready), 32'd1);
        check("post_rst_count", 32'(bus.count), 32'd0);
        check("post_rst_err", 32'(bus.err), 32'd0);
        check("post_rst_fault_bits", 32'(bus.fault_bits), 32'd0);
        check("post_rst_done", 32'(bus.done), 32'd0);
        m_count = 4'd0;
    endtask

    initial begin
        logic [3:0] nxt;
        n_cmp        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        stuck0       = 4'b0000;
        bus.en       = 1'b0;
        bus.up       = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 4'd0;
        m_count      = 4'd0;
        @(negedge clk);

        // Reset sequence.
        do_reset();

        // Up count held for 30 steps: 0..9 repeated, wrap only on 9 -> 0.
        for (int i = 0; i < 30; i++) begin
            nxt = (m_count == 4'd9) ? 4'd0 : m_count + 4'd1;
            do_step(1'b0, 4'd0, 1'b1, nxt, (m_count == 4'd9), 1'b1);
        end
        bus.en = 1'b0;
        check("up30_final_count", 32'(bus.count), 32'd0);

        // Down wrap from 0: s=1001, r=0000, count 9 with wrap.
        do_step(1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
        // Down 9 -> 8: r=0001.
        do_step(1'b0, 4'd0, 1'b0, 4'd8, 1'b0, 1'b0);
        // Load beats en (which would give 7); 13 clamps to 9; no wrap.
        do_step(1'b1, 4'd13, 1'b0, 4'd9, 1'b0, 1'b0);
        // Load of the current value: s=r=0 but done still pulses.
        do_step(1'b1, 4'd9, 1'b1, 4'd9, 1'b0, 1'b0);
        // Load 1 ahead of the fault test.
        do_step(1'b1, 4'd1, 1'b1, 4'd1, 1'b0, 1'b0);

        // Idle with no request: stays ready, nothing driven.
        @(negedge clk);
        check("idle_ready", 32'(bus.ready), 32'd1);
        check("idle_sr", 32'({bus.s, bus.r}), 32'd0);

        // Fault: bit 1 stuck at 0, step 1 -> 2.
        stuck0  = 4'b0010;
        bus.en  = 1'b1;
        bus.up  = 1'b1;
        @(negedge clk);
        check("fault_drive_s", 32'(bus.s), 32'h2);
        check("fault_drive_r", 32'(bus.r), 32'h1);
        @(negedge clk);
        @(negedge clk);
        check("fault_err", 32'(bus.err), 32'd1);
        check("fault_bits", 32'(bus.fault_bits), 32'h2);
        check("fault_count_kept", 32'(bus.count), 32'd1);
        check("fault_done", 32'(bus.done), 32'd0);
        check("fault_ready", 32'(bus.ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.load = (i == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            check("fault_hold_sr", 32'({bus.s, bus.r}), 32'd0);
            check("fault_hold_err", 32'(bus.err), 32'd1);
            check("fault_hold_ready", 32'(bus.ready), 32'd0);
        end
        bus.en   = 1'b0;
        bus.load = 1'b0;
        stuck0   = 4'b0000;

        // Reset clears the sticky fault.
        do_reset();

        // Mid-operation reset: load 5, reset while in DRIVE.
        bus.load     = 1'b1;
        bus.load_val = 4'd5;
        bus.en       = 1'b0;
        @(negedge clk);
        check("mid_drive_s", 32'(bus.s), 32'h5);
        bus.load = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("mid_clear_r", 32'(bus.r), 32'hF);
        check("mid_clear_s", 32'(bus.s), 32'd0);
        check("mid_clear_done", 32'(bus.done), 32'd0);
        check("mid_clear_count", 32'(bus.count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_verify_done", 32'(bus.done), 32'd0);
        check("mid_verify_q", 32'(bus.q_fb), 32'd0);
        @(negedge clk);
        check("mid_end_ready", 32'(bus.ready), 32'd1);
        check("mid_end_done", 32'(bus.done), 32'd0);
        check("mid_end_count", 32'(bus.count), 32'd0);
        check("mid_end_err", 32'(bus.err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
